// File: rtl/mult4x4_initiator.sv
// Requester-side controller for the 4x4 multiplier handshake.
// Launches one operation at a time, captures the product and keeps a saturating running sum.
module mult4x4_initiator #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int ACC_WIDTH      = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 req,
    input  logic [3:0]           op_a,
    input  logic [3:0]           op_b,
    input  logic                 acc_clr,
    output logic                 busy,
    output logic                 start,
    output logic [3:0]           dataa,
    output logic [3:0]           datab,
    input  logic                 done_flag,
    input  logic [7:0]           product,
    output logic [7:0]           result,
    output logic                 result_valid,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 timeout_err
);

    // state     | meaning
    // S_IDLE    | waiting for ena && req
    // S_LAUNCH  | start pulse high, timer loaded
    // S_WAIT    | waiting for done_flag rising edge or timer expiry
    // S_CAPTURE | result_valid high, accumulator updated
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE} state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]        TIMER_LOAD = TW'(TIMEOUT_CYCLES);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX    = '1;

    state_t          state;
    logic [TW-1:0]   timer;
    logic            done_q;
    logic            done_rise;
    logic [ACC_WIDTH:0] acc_sum;

    // A flag that was already high when sampled never counts as completion.
    assign done_rise = done_flag & ~done_q;
    assign acc_sum   = {1'b0, acc} + (ACC_WIDTH + 1)'(result);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            timer        <= '0;
            done_q       <= 1'b0;
            busy         <= 1'b0;
            start        <= 1'b0;
            dataa        <= '0;
            datab        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            acc          <= '0;
            timeout_err  <= 1'b0;
        end else begin
            done_q       <= done_flag;
            start        <= 1'b0;
            result_valid <= 1'b0;
            if (acc_clr) acc <= '0;

            case (state)
                S_IDLE: begin
                    if (ena && req) begin
                        dataa       <= op_a;
                        datab       <= op_b;
                        timeout_err <= 1'b0;
                        start       <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    timer <= TIMER_LOAD;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer - TW'(1);
                    // Completion takes priority over an expiring timer.
                    if (done_rise) begin
                        result       <= product;
                        result_valid <= 1'b1;
                        state        <= S_CAPTURE;
                    end else if (timer == TW'(1)) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_CAPTURE: begin
                    if (acc_clr)
                        acc <= ACC_WIDTH'(result);
                    else
                        acc <= acc_sum[ACC_WIDTH] ? ACC_MAX : acc_sum[ACC_WIDTH-1:0];
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
